// File: rtl/reaction_timer.sv
// Game-control core of the reaction-time game: random pre-delay, GO cue, then reaction
// measured in prescaled ticks, saturated at MAX_COUNT, with false-start detection.
module reaction_timer #(
  parameter int unsigned TICK_DIV  = 500000,
  parameter int unsigned MIN_DELAY = 100,
  parameter int unsigned MAX_COUNT = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       led_go,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       false_start,
  output logic       busy
);

  localparam int unsigned       PrescW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);
  localparam logic [8:0]        MinDly   = 9'(MIN_DELAY);
  localparam logic [7:0]        MaxCnt   = 8'(MAX_COUNT);

  typedef enum logic [2:0] {StIdle, StWait, StGo, StDone, StFalse} state_e;

  state_e            state_q;
  logic [PrescW-1:0] presc_q;
  logic [8:0]        delay_q;
  logic [7:0]        count_q;
  logic              btn_q;
  logic [7:0]        lfsr_q;
  logic              led_go_q;
  logic [7:0]        result_q;
  logic              result_valid_q;
  logic              false_start_q;
  logic              busy_q;

  logic       press;
  logic       tick;
  logic [7:0] lfsr_d;

  assign press  = btn & ~btn_q;
  assign tick   = (presc_q == PrescMax);
  // x^8 + x^6 + x^5 + x^4 + 1
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      presc_q        <= '0;
      delay_q        <= '0;
      count_q        <= '0;
      btn_q          <= 1'b0;
      lfsr_q         <= 8'h01;
      led_go_q       <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      false_start_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      btn_q   <= btn;
      lfsr_q  <= lfsr_d;
      presc_q <= tick ? '0 : presc_q + PrescW'(1);
      unique case (state_q)
        StIdle, StDone, StFalse: begin
          if (press) begin
            state_q        <= StWait;
            delay_q        <= MinDly + {2'b00, lfsr_q[6:0]};
            presc_q        <= '0;
            busy_q         <= 1'b1;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            false_start_q  <= 1'b0;
            led_go_q       <= 1'b0;
          end
        end
        StWait: begin
          if (press) begin
            // A press before GO wins even over an expiring delay
            state_q       <= StFalse;
            busy_q        <= 1'b0;
            false_start_q <= 1'b1;
            result_q      <= '0;
          end else if (tick) begin
            if (delay_q <= 9'd1) begin
              state_q  <= StGo;
              count_q  <= '0;
              presc_q  <= '0;
              led_go_q <= 1'b1;
            end else begin
              delay_q <= delay_q - 9'd1;
            end
          end
        end
        StGo: begin
          if (press) begin
            state_q        <= StDone;
            result_q       <= count_q;
            result_valid_q <= 1'b1;
            led_go_q       <= 1'b0;
            busy_q         <= 1'b0;
          end else if (tick) begin
            if (count_q >= MaxCnt - 8'd1) begin
              state_q        <= StDone;
              count_q        <= MaxCnt;
              result_q       <= MaxCnt;
              result_valid_q <= 1'b1;
              led_go_q       <= 1'b0;
              busy_q         <= 1'b0;
            end else begin
              count_q <= count_q + 8'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign led_go       = led_go_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign false_start  = false_start_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Randomised scoreboard bench for reaction_timer: each round plan pushes its expected
// output changes (edge number + output tuple); a monitor pops them as outputs change.
module tb_reaction_timer;

  localparam int TickDiv  = 4;
  localparam int MinDelay = 2;
  localparam int MaxCount = 99;

  localparam int KReact   = 0;
  localparam int KFalse   = 1;
  localparam int KTimeout = 2;
  localparam int KReset   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       led_go;
  logic [7:0] result;
  logic       result_valid;
  logic       false_start;
  logic       busy;

  reaction_timer #(
    .TICK_DIV (TickDiv),
    .MIN_DELAY(MinDelay),
    .MAX_COUNT(MaxCount)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .led_go      (led_go),
    .result      (result),
    .result_valid(result_valid),
    .false_start (false_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       led_go;
    logic [7:0] result;
    logic       valid;
    logic       fs;
    logic       busy;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  localparam obs_t ObsZero  = '{led_go: 1'b0, result: 8'd0, valid: 1'b0, fs: 1'b0, busy: 1'b0};
  localparam obs_t ObsWait  = '{led_go: 1'b0, result: 8'd0, valid: 1'b0, fs: 1'b0, busy: 1'b1};
  localparam obs_t ObsGo    = '{led_go: 1'b1, result: 8'd0, valid: 1'b0, fs: 1'b0, busy: 1'b1};
  localparam obs_t ObsFalse = '{led_go: 1'b0, result: 8'd0, valid: 1'b0, fs: 1'b1, busy: 1'b0};

  exp_t       q[$];
  int         cyc      = 0;
  int         n_vec    = 0;
  int         n_err    = 0;
  int         lfsr_bad = 0;
  bit         mon_en   = 1'b0;
  bit         lfsr_en  = 1'b0;
  logic [7:0] m_lfsr;
  obs_t       prev;
  obs_t       cur;
  exp_t       ex;

  function automatic obs_t done_obs(input int r);
    obs_t o;
    o        = ObsZero;
    o.result = 8'(r);
    o.valid  = 1'b1;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.led_go = led_go;
    o.result = result;
    o.valid  = result_valid;
    o.fs     = false_start;
    o.busy   = busy;
    return o;
  endfunction

  function automatic void push(input int c, input obs_t o);
    exp_t e;
    e.cyc = c;
    e.o   = o;
    q.push_back(e);
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  // Edge counter: at a negedge, cyc is the number of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) m_lfsr <= rst ? 8'h01 : lfsr_next(m_lfsr);

  always @(negedge clk) begin
    if (lfsr_en) begin
      n_vec++;
      if (dut.lfsr_q !== m_lfsr || dut.lfsr_q == 8'h00) begin
        n_err++;
        lfsr_bad++;
        if (lfsr_bad <= 5)
          $display("FAIL lfsr edge=%0d got=%h want=%h (nonzero)", cyc, dut.lfsr_q, m_lfsr);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      cur = sample();
      if (cur !== prev) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change edge=%0d got=%h want=no change", cyc, cur);
        end else begin
          ex = q.pop_front();
          if (ex.o !== cur || ex.cyc != cyc) begin
            n_err++;
            $display("FAIL output_change got=%h@%0d want=%h@%0d", cur, cyc, ex.o, ex.cyc);
          end else if (ex.o.valid && ex.o.result == 8'(MaxCount)) begin
            n_vec++;
            if (cur.result / 10 != MaxCount / 10 || cur.result % 10 != MaxCount % 10) begin
              n_err++;
              $display("FAIL bcd_digits got=%0d%0d want=%0d%0d", cur.result / 10,
                       cur.result % 10, MaxCount / 10, MaxCount % 10);
            end
          end
        end
        prev = cur;
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missed_change edge=%0d got=%h want=%h@%0d", cyc, cur, q[0].o, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  // Returns at the negedge immediately before rising edge e.
  task automatic wait_edge(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  task automatic pulse(input int hold);
    btn = 1'b1;
    repeat (hold) @(negedge clk);
    btn = 1'b0;
  endtask

  // One round from a non-busy state; the whole plan is known up front so every expected
  // output change is queued before it can occur.
  task automatic run_round(input int kind, input int arg, input int hold);
    int p, d, go, e, win;
    @(negedge clk);
    p  = cyc + 1;
    d  = MinDelay + int'(m_lfsr[6:0]);
    go = p + TickDiv * d;
    push(p, ObsWait);
    pulse(1);
    case (kind)
      KFalse: begin
        win = TickDiv * d - 1;
        e   = (arg < 0) ? go : p + 2 + (arg % win);
        push(e, ObsFalse);
        wait_edge(e);
        pulse(hold);
      end
      KReact: begin
        e = go + arg;
        push(go, ObsGo);
        push(e, done_obs((arg - 1) / TickDiv));
        wait_edge(e);
        pulse(hold);
      end
      KTimeout: begin
        e = go + TickDiv * MaxCount;
        push(go, ObsGo);
        push(e, done_obs(MaxCount));
        wait_edge(e + 2);
      end
      default: begin
        e = go + arg;
        push(go, ObsGo);
        push(e, ObsZero);
        wait_edge(e);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    endcase
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog edge=%0d want=bench completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind;
    rst = 1'b1;
    btn = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (sample() !== ObsZero) begin
      n_err++;
      $display("FAIL reset_outputs got=%h want=%h", sample(), ObsZero);
    end
    prev    = ObsZero;
    mon_en  = 1'b1;
    lfsr_en = 1'b1;
    rst     = 1'b0;
    repeat (300) @(negedge clk);

    run_round(KReact, 22, 5);
    run_round(KFalse, 7, 1);
    run_round(KReact, 9, 1);
    run_round(KTimeout, 0, 1);
    run_round(KReset, 150, 1);
    run_round(KFalse, -1, 2);
    run_round(KReact, TickDiv * MaxCount, 2);
    run_round(KReact, 1, 1);
    run_round(KReact, TickDiv, 1);

    for (int i = 0; i < 12; i++) begin
      kind = int'($urandom_range(0, 2));
      case (kind)
        KReact:  run_round(KReact, int'($urandom_range(1, TickDiv * MaxCount)),
                           int'($urandom_range(1, 4)));
        KFalse:  run_round(KFalse, int'($urandom_range(0, 1000)), int'($urandom_range(1, 4)));
        default: run_round(KTimeout, 0, 1);
      endcase
    end

    repeat (5) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL pending_expectations got=%0d want=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Game-control core of the reaction-time game, directly upstream of the binary-to-BCD converter.
- Runs the round: random pre-delay, GO cue, then measures player reaction in 10 ms ticks.
- Drives an 8-bit result, saturated at 99, which the BCD stage converts to tens/ones digits.
- Also flags false starts (press before GO).

Parameters:
- TICK_DIV, 500000: clk cycles per timing tick (50 MHz -> 10 ms); benches override to 4.
- MIN_DELAY, 100: minimum pre-GO delay in ticks.
- MAX_COUNT, 99: reaction count saturation/timeout value; must be < 256.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- btn  in  1  player button, debounced and synchronised upstream, level-high when pressed.
- led_go  out  1  GO cue; high only in state GO.
- result  out  8  reaction time in ticks, 0..MAX_COUNT; feeds bin input of BCD stage.
- result_valid  out  1  high while a valid result is held (state DONE).
- false_start  out  1  high while in state FALSE.
- busy  out  1  high in WAIT or GO.

Behaviour:
- Reset values: all outputs 0, state IDLE, tick prescaler 0, counters 0, btn_q 0, LFSR 8'h01.
- Edge detect: btn_q registers btn each cycle; press = btn & ~btn_q. Only press events act; holding btn does nothing further.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every clk including reset release. Never reaches 0.
- Tick: prescaler counts 0..TICK_DIV-1; tick pulses for one cycle when prescaler = TICK_DIV-1, then wraps. Prescaler clears on every entry to WAIT or GO, so the first tick comes exactly TICK_DIV cycles after entry.
- All outputs are registered. A transition taken on cycle N is visible on outputs at cycle N+1.
- IDLE:
  - press -> WAIT.
  - delay counter loads MIN_DELAY + LFSR[6:0] as sampled on the press cycle.
- WAIT:
  - each tick decrements the delay counter.
  - press (any cycle, including the tick cycle) -> FALSE; press has priority over expiry.
  - tick with delay counter = 1 -> GO, with reaction count cleared.
- GO:
  - each tick increments the reaction count.
  - press -> DONE; result = reaction count as of that cycle (a tick in the same cycle is not counted).
  - tick with count = MAX_COUNT-1 -> count reaches MAX_COUNT -> DONE with result = MAX_COUNT (timeout). Result never exceeds MAX_COUNT.
- DONE:
  - result held, result_valid = 1.
  - press -> WAIT (new round, new delay load); result_valid drops and result clears to 0 on that transition.
- FALSE:
  - result = 0, false_start = 1.
  - press -> WAIT (retry) and false_start clears.
- rst mid-round: returns to IDLE on the next edge regardless of state. Any in-progress count is discarded.
- Width rules:
  - delay counter is 9 bits; max load = MIN_DELAY + 127, which must be < 512.
  - reaction count is 8 bits; prescaler is ceil(log2(TICK_DIV)) bits.

Test Plan (TICK_DIV=4, MIN_DELAY=2, MAX_COUNT=99):
1. Reset held 3 cycles, btn=0 -> all outputs 0, busy=0; LFSR never 0 over 300 cycles.
2. Press in IDLE -> busy=1 next cycle; led_go rises between 8 and 516 cycles later, and exactly 4*(2+LFSR[6:0]) cycles after the press cycle per the bench's LFSR model.
3. Press 22 cycles after the led_go rise cycle -> result=5, result_valid=1, led_go=0, busy=0; result holds while btn stays high.
4. Press during WAIT before GO -> false_start=1, result=0, led_go never asserts. Next press -> false_start=0, busy=1.
5. No press after GO -> after 396 cycles: result=99, result_valid=1, led_go=0; the BCD stage shows tens=9, ones=9.
6. rst asserted mid-GO with count=37 -> next cycle state IDLE, all outputs 0. A subsequent press starts a fresh round.
